// File: rtl/fp_op_sequencer.sv
// fp_op_sequencer: queues {op,a,b} pairs and walks the FP add unit through launch/wait/release,
// one operation in flight, presenting each result on a valid/ready port. Macro: FP_SEQ_TIMEOUT_EN.
module fp_op_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_a,
  input  logic [31:0]                in_b,
  input  logic                       in_op,
  output logic                       fpu_start,
  output logic                       fpu_op,
  output logic [31:0]                fpu_a,
  output logic [31:0]                fpu_b,
  input  logic                       fpu_busy,
  input  logic                       fpu_ready,
  input  logic [31:0]                fpu_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic                       out_err,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int LW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_REL, S_DRAIN} state_e;
  state_e state_q, state_d;

  logic [64:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          push_s, pop_s, full_s, empty_s, timeout_s, unused_s;
  logic [64:0]   head_s;
  logic          fpu_start_q, fpu_start_d, fpu_op_q, fpu_op_d;
  logic [31:0]   fpu_a_q, fpu_a_d, fpu_b_q, fpu_b_d;
  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_data_q, out_data_d;

  assign full_s   = (level_q == LW'(DEPTH));
  assign empty_s  = (level_q == {LW{1'b0}});
  assign in_ready = !full_s;
  assign push_s   = in_valid && !full_s;
  // Pop waits for the previous result to be taken, so handshake and pop never share a cycle.
  assign pop_s    = (state_q == S_IDLE) && !empty_s && !out_valid_q;
  assign head_s   = mem_q[rd_ptr_q];
  assign unused_s = fpu_busy ^ (TIMEOUT > 0);

  // Operand FIFO storage, pointers and occupancy
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 65'd0;
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      level_q  <= {LW{1'b0}};
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= {in_op, in_a, in_b};
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_s) rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q <= level_d;
    end
  end

  // Occupancy next state
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

`ifdef FP_SEQ_TIMEOUT_EN
  logic [7:0] wd_q, wd_d;
  logic       out_err_q, out_err_d;

  // Watchdog counts S_WAIT cycles and restarts from zero on every entry
  always_comb begin
    if (state_q == S_WAIT) wd_d = wd_q + 8'd1;
    else                   wd_d = 8'd0;
    if ((state_q == S_WAIT) && fpu_ready) out_err_d = 1'b0;
    else if (timeout_s)                   out_err_d = 1'b1;
    else                                  out_err_d = out_err_q;
  end

  assign timeout_s = (state_q == S_WAIT) && !fpu_ready && (wd_d == 8'(TIMEOUT));

  // Watchdog and error flag registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_q      <= 8'd0;
      out_err_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      out_err_q <= out_err_d;
    end
  end

  assign out_err = out_err_q;
`else
  assign timeout_s = 1'b0;
  assign out_err   = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    case (state_q)
      S_IDLE:  state_d = pop_s ? S_START : S_IDLE;
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (fpu_ready)      state_d = S_REL;
        else if (timeout_s) state_d = S_IDLE;
        else                state_d = S_WAIT;
      end
      S_REL:   state_d = S_DRAIN;
      S_DRAIN: state_d = fpu_ready ? S_DRAIN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs; start is decoded from the next state so the registered pulse lines up with it
  always_comb begin
    fpu_start_d = (state_d == S_START) || (state_d == S_REL);
    if (pop_s) begin
      fpu_op_d = head_s[64];
      fpu_a_d  = head_s[63:32];
      fpu_b_d  = head_s[31:0];
    end else begin
      fpu_op_d = fpu_op_q;
      fpu_a_d  = fpu_a_q;
      fpu_b_d  = fpu_b_q;
    end
    if (out_valid_q && out_ready)                               out_valid_d = 1'b0;
    else if (((state_q == S_DRAIN) && !fpu_ready) || timeout_s) out_valid_d = 1'b1;
    else                                                        out_valid_d = out_valid_q;
    if ((state_q == S_WAIT) && fpu_ready) out_data_d = fpu_result;
    else if (timeout_s)                   out_data_d = 32'h7FC0_0000;
    else                                  out_data_d = out_data_q;
  end

  // Registered FPU drive and result port
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fpu_start_q <= 1'b0;
      fpu_op_q    <= 1'b0;
      fpu_a_q     <= 32'd0;
      fpu_b_q     <= 32'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
    end else begin
      fpu_start_q <= fpu_start_d;
      fpu_op_q    <= fpu_op_d;
      fpu_a_q     <= fpu_a_d;
      fpu_b_q     <= fpu_b_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign fpu_start = fpu_start_q;
  assign fpu_op    = fpu_op_q;
  assign fpu_a     = fpu_a_q;
  assign fpu_b     = fpu_b_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign level     = level_q;
endmodule

// File: tb/tb_fp_op_sequencer.sv
// Scoreboard bench for fp_op_sequencer with a behavioural FPU model (ready DELAY cycles after
// a launch start, dropped on the release start). Define FP_SEQ_TIMEOUT_EN to cover the watchdog.
module tb_fp_op_sequencer;
  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_op;
  logic [31:0] in_a, in_b;
  logic        fpu_start, fpu_op, fpu_busy, fpu_ready;
  logic [31:0] fpu_a, fpu_b, fpu_result;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_data;
  logic [2:0]  level;

  fp_op_sequencer dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_busy(fpu_busy), .fpu_ready(fpu_ready), .fpu_result(fpu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .level(level)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e_new, e_pop;
  int          tests_run = 0;
  int          fails = 0;
  int          start_cnt = 0;
  int          delay = 4;
  bit          never_ready = 1'b0;
  logic        prev_start, hold_armed, hold_err;
  logic [31:0] la, lb, hold_data;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference result: doubling for equal add operands, otherwise an asymmetric mix
  function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b, input logic op);
    if (!op && (a == b)) return {a[31], a[30:23] + 8'd1, a[22:0]};
    return a + {b[15:0], b[31:16]} + {31'd0, op};
  endfunction

  // FPU model
  logic        m_ready, m_arm;
  logic [31:0] m_res, m_val;
  int          m_cnt;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_ready <= 1'b0; m_arm <= 1'b0; m_res <= 32'd0; m_val <= 32'd0; m_cnt <= 0;
    end else if (fpu_start && m_ready) begin
      m_ready <= 1'b0;
    end else if (fpu_start) begin
      if (!never_ready) begin
        m_arm <= 1'b1; m_cnt <= delay; m_val <= fpu_fn(fpu_a, fpu_b, fpu_op);
      end
    end else if (m_arm) begin
      if (m_cnt == 1) begin
        m_ready <= 1'b1; m_arm <= 1'b0; m_res <= m_val;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end
  assign fpu_ready  = m_ready;
  assign fpu_busy   = m_arm;
  assign fpu_result = m_ready ? m_res : 32'hFFFF_FFFF;

  // Monitor: start pulses, operand hold, scoreboard push/pop, output stability
  always @(negedge clock) begin
    if (!reset) begin
      hold_armed = 1'b0;
      prev_start = 1'b0;
    end else begin
      if (fpu_start) begin
        start_cnt++;
        check_eq("start_single_cycle", 32'(prev_start), 32'd0);
        if (!fpu_ready) begin
          la = fpu_a; lb = fpu_b;
        end else begin
          check_eq("fpu_a_hold", fpu_a, la);
          check_eq("fpu_b_hold", fpu_b, lb);
        end
      end
      prev_start = fpu_start;
      if (in_valid && in_ready) begin
        e_new.err  = never_ready;
        e_new.data = never_ready ? 32'h7FC0_0000 : fpu_fn(in_a, in_b, in_op);
        sb_q.push_back(e_new);
      end
      if (out_valid) begin
        if (hold_armed) begin
          check_eq("out_data_stable", out_data, hold_data);
          check_eq("out_err_stable", 32'(out_err), 32'(hold_err));
        end
        if (out_ready) begin
          if (sb_q.size() == 0) begin
            check_eq("unexpected_result", 32'd1, 32'd0);
          end else begin
            e_pop = sb_q.pop_front();
            check_eq("out_data", out_data, e_pop.data);
            check_eq("out_err", 32'(out_err), 32'(e_pop.err));
          end
          hold_armed = 1'b0;
        end else begin
          hold_armed = 1'b1; hold_data = out_data; hold_err = out_err;
        end
      end else begin
        hold_armed = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic push_pair(input logic [31:0] a, input logic [31:0] b, input logic op);
    bit ok = 1'b0;
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check_eq("push_accept_timeout", 32'd0, 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(input int budget);
    bit ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clock);
      if (out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) check_eq("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clock);
      if (sb_q.size() == 0 && !out_valid && level == 3'd0) begin ok = 1'b1; break; end
    end
    if (!ok) check_eq("drain_timeout", 32'(sb_q.size()), 32'd0);
    tick();
  endtask

  initial begin
    int s0, n;
    bit ok;
    reset = 1'b0; in_valid = 1'b0; in_a = 32'd0; in_b = 32'd0; in_op = 1'b0; out_ready = 1'b1;
    #12;
    check_eq("rst_fpu_start", 32'(fpu_start), 32'd0);
    check_eq("rst_fpu_a", fpu_a, 32'd0);
    check_eq("rst_fpu_b", fpu_b, 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", out_data, 32'd0);
    check_eq("rst_out_err", 32'(out_err), 32'd0);
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    #11 reset = 1'b1;
    tick();

    // 1: single add, two start pulses
    s0 = start_cnt;
    push_pair(32'h3F80_0000, 32'h3F80_0000, 1'b0);
    wait_idle(200);
    check_eq("t1_start_pulses", 32'(start_cnt - s0), 32'd2);

    // 2: fill with the output stalled, then drain in order
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_pair($urandom, $urandom, 1'(i % 2));
    @(negedge clock);
    check_eq("t2_in_ready_full", 32'(in_ready), 32'd0);
    check_eq("t2_level_full", 32'(level), 32'd4);
    wait_out_valid(200);
    tick();
    out_ready = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (level != 3'd4) begin ok = 1'b1; break; end
    end
    check_eq("t2_level_after_pop", 32'(level), 32'd3);
    wait_idle(500);

    // 3: push and pop in the same cycle at level 2
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_pair($urandom, $urandom, 1'b0);
    wait_out_valid(200);
    check_eq("t3_level_before", 32'(level), 32'd2);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_a = $urandom; in_b = $urandom; in_op = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clock);
    check_eq("t3_level_same", 32'(level), 32'd2);
    tick();
    out_ready = 1'b1;
    wait_idle(500);

`ifdef FP_SEQ_TIMEOUT_EN
    // 4: watchdog abort after 16 cycles in S_WAIT
    never_ready = 1'b1;
    push_pair(32'h4040_0000, 32'h3F80_0000, 1'b0);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (fpu_start) begin ok = 1'b1; break; end
    end
    check_eq("t4_launch_seen", 32'(ok), 32'd1);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (out_valid) break;
      n++;
    end
    check_eq("t4_wait_cycles", 32'(n), 32'd16);
    wait_idle(100);
    never_ready = 1'b0;
    push_pair(32'h4000_0000, 32'h4000_0000, 1'b0);
    wait_idle(200);
`else
    // 6: slow FPU without watchdog
    delay = 100;
    push_pair(32'h4120_0000, 32'h3F00_0000, 1'b0);
    wait_idle(400);
    delay = 4;
`endif

    // 5: reset during S_WAIT with three pairs queued
    delay = 20;
    for (int i = 0; i < 4; i++) push_pair($urandom, $urandom, 1'b0);
    @(negedge clock);
    check_eq("t5_level_before", 32'(level), 32'd3);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    check_eq("t5_rst_fpu_start", 32'(fpu_start), 32'd0);
    check_eq("t5_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("t5_rst_level", 32'(level), 32'd0);
    sb_q.delete();
    #20 reset = 1'b1;
    delay = 4;
    s0 = start_cnt;
    repeat (30) tick();
    check_eq("t5_no_start", 32'(start_cnt - s0), 32'd0);
    check_eq("t5_no_result", 32'(out_valid), 32'd0);
    check_eq("t5_level_empty", 32'(level), 32'd0);
    push_pair(32'h3F80_0000, 32'h3F80_0000, 1'b0);
    wait_idle(200);
    check_eq("t5_restart_pulses", 32'(start_cnt - s0), 32'd2);

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
